// File: rtl/layer_priority_arbiter.sv
// Per-pixel colour arbiter: picks one layer colour per pixel from a programmable priority
// table, with frame-committed enable/blink masks and per-frame overlap reporting.
module layer_priority_arbiter #(
  parameter int unsigned NUM_LAYERS   = 9,
  parameter int unsigned COLOR_W      = 8,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic [NUM_LAYERS-1:0]         layerReq,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layerRGB,
  input  logic [COLOR_W-1:0]            bgrRGB,
  input  logic                          prioWr,
  input  logic [3:0]                    prioSlot,
  input  logic [3:0]                    prioLayer,
  input  logic                          enMaskWr,
  input  logic [NUM_LAYERS-1:0]         enMaskIn,
  input  logic [NUM_LAYERS-1:0]         blinkMask,
  output logic [COLOR_W-1:0]            rgbOut,
  output logic [3:0]                    winner,
  output logic                          winnerValid,
  output logic [NUM_LAYERS-1:0]         collisionMask
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_FRAMES / 2);
  localparam logic [IDX_W:0]   NUM_L    = (IDX_W+1)'(NUM_LAYERS);

  logic [IDX_W-1:0]        shadow_prio     [NUM_LAYERS];
  logic [IDX_W-1:0]        shadow_prio_nxt [NUM_LAYERS];
  logic [IDX_W-1:0]        active_prio     [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]   shadow_en, active_en, blink_lat;
  logic [CNT_W-1:0]        frame_cnt, frame_cnt_nxt;
  logic [NUM_LAYERS-1:0]   hit_acc, hit_term;

  logic                    swap_ok;
  logic [IDX_W-1:0]        t_slot, old_at_slot;

  logic [NUM_LAYERS-1:0]   en_now, blink_now, eff_req;
  logic                    blink_off;

  logic [NUM_LAYERS-1:0]   s1_eff;
  logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb;
  logic [COLOR_W-1:0]      s1_bgr;

  logic [15:0]             req16;
  logic                    win_found;
  logic [IDX_W-1:0]        win_layer;
  logic [COLOR_W-1:0]      win_rgb;

  // Frame counter advances on each frame start and wraps at the blink period
  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (startOfFrame) begin
      frame_cnt_nxt = (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
    end
  end

  // Priority write is a swap with whichever slot currently holds the target layer
  always_comb begin
    swap_ok     = prioWr && ({1'b0, prioSlot} < NUM_L) && ({1'b0, prioLayer} < NUM_L);
    t_slot      = '0;
    old_at_slot = '0;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      if (shadow_prio[s] == prioLayer) t_slot = IDX_W'(s);
      if (IDX_W'(s) == prioSlot)       old_at_slot = shadow_prio[s];
    end
    shadow_prio_nxt = shadow_prio;
    if (swap_ok) begin
      for (int s = 0; s < NUM_LAYERS; s++) begin
        if (IDX_W'(s) == prioSlot)    shadow_prio_nxt[s] = prioLayer;
        else if (IDX_W'(s) == t_slot) shadow_prio_nxt[s] = old_at_slot;
      end
    end
  end

  // A frame-start pixel already sees the values being committed on that edge
  always_comb begin
    en_now    = startOfFrame ? shadow_en : active_en;
    blink_now = startOfFrame ? blinkMask : blink_lat;
    blink_off = (frame_cnt_nxt >= CNT_HALF);
    eff_req   = layerReq & en_now & ~(blink_now & {NUM_LAYERS{blink_off}});
  end

  // Overlap term: two or more effective requests on the same pixel
  always_comb begin
    hit_term = '0;
    if ((s1_eff & (s1_eff - NUM_LAYERS'(1))) != '0) hit_term = s1_eff;
  end

  // Stage-2 scan: lowest slot with an active request wins
  always_comb begin
    req16     = 16'(s1_eff);
    win_found = 1'b0;
    win_layer = '0;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      if (!win_found && req16[active_prio[s]]) begin
        win_found = 1'b1;
        win_layer = active_prio[s];
      end
    end
    win_rgb = s1_bgr;
    if (win_found) begin
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (IDX_W'(l) == win_layer) win_rgb = s1_rgb[l*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_prio[i] <= IDX_W'(i);
        active_prio[i] <= IDX_W'(i);
      end
      shadow_en     <= '1;
      active_en     <= '1;
      blink_lat     <= '0;
      frame_cnt     <= '0;
      hit_acc       <= '0;
      s1_eff        <= '0;
      s1_rgb        <= '0;
      s1_bgr        <= '0;
      rgbOut        <= '0;
      winner        <= '0;
      winnerValid   <= 1'b0;
      collisionMask <= '0;
    end else begin
      shadow_prio <= shadow_prio_nxt;
      if (enMaskWr) shadow_en <= enMaskIn;
      frame_cnt <= frame_cnt_nxt;
      if (startOfFrame) begin
        active_prio   <= shadow_prio;
        active_en     <= shadow_en;
        blink_lat     <= blinkMask;
        collisionMask <= hit_acc;
        hit_acc       <= hit_term;
      end else begin
        hit_acc <= hit_acc | hit_term;
      end
      s1_eff      <= eff_req;
      s1_rgb      <= layerRGB;
      s1_bgr      <= bgrRGB;
      rgbOut      <= win_rgb;
      winner      <= win_found ? win_layer : '0;
      winnerValid <= win_found;
    end
  end

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Scoreboard bench for layer_priority_arbiter: directed pixels push expected outputs,
// a negedge monitor pops and compares them when they are due.
module tb_layer_priority_arbiter;

  localparam int unsigned NL = 9;
  localparam int unsigned CW = 8;

  logic              clk;
  logic              reset;
  logic              startOfFrame;
  logic [NL-1:0]     layerReq;
  logic [NL*CW-1:0]  layerRGB;
  logic [CW-1:0]     bgrRGB;
  logic              prioWr;
  logic [3:0]        prioSlot;
  logic [3:0]        prioLayer;
  logic              enMaskWr;
  logic [NL-1:0]     enMaskIn;
  logic [NL-1:0]     blinkMask;
  logic [CW-1:0]     rgbOut;
  logic [3:0]        winner;
  logic              winnerValid;
  logic [NL-1:0]     collisionMask;

  layer_priority_arbiter #(.NUM_LAYERS(NL), .COLOR_W(CW), .BLINK_FRAMES(16)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .layerReq(layerReq),
    .layerRGB(layerRGB), .bgrRGB(bgrRGB), .prioWr(prioWr), .prioSlot(prioSlot),
    .prioLayer(prioLayer), .enMaskWr(enMaskWr), .enMaskIn(enMaskIn), .blinkMask(blinkMask),
    .rgbOut(rgbOut), .winner(winner), .winnerValid(winnerValid), .collisionMask(collisionMask)
  );

  typedef struct {
    int          due;
    int          kind;   // 0 pixel, 1 collision mask, 2 all outputs zero
    logic [7:0]  rgb;
    logic [3:0]  win;
    logic        vld;
    logic [8:0]  col;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  localparam logic [7:0] BG = 8'h49;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int due, input int kind, input logic [7:0] rgb,
                               input logic [3:0] win, input logic vld, input logic [8:0] col,
                               input string nm);
    exp_t e;
    e.due = due; e.kind = kind; e.rgb = rgb; e.win = win; e.vld = vld; e.col = col;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endfunction

  // Monitor: compare every expectation whose output is due this cycle
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    logic  bad;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      case (e.kind)
        0:       bad = (rgbOut !== e.rgb) || (winner !== e.win) || (winnerValid !== e.vld);
        1:       bad = (collisionMask !== e.col);
        default: bad = (rgbOut !== 8'h00) || (winner !== 4'h0) || (winnerValid !== 1'b0) ||
                       (collisionMask !== 9'h000);
      endcase
      if (e.due != cyc) bad = 1'b1;
      if (bad) begin
        n_fail++;
        $display("FAIL %s: got rgb=%h win=%0d vld=%b col=%h, want rgb=%h win=%0d vld=%b col=%h (due %0d, cyc %0d)",
                 nm, rgbOut, winner, winnerValid, collisionMask, e.rgb, e.win, e.vld, e.col,
                 e.due, cyc);
      end
    end
  end

  task automatic pix(input logic [8:0] req, input logic sof, input logic chk,
                     input logic [7:0] ergb, input logic [3:0] ew, input logic ev,
                     input string nm);
    layerReq     = req;
    startOfFrame = sof;
    if (chk) push(cyc + 2, 0, ergb, ew, ev, 9'h000, nm);
    @(posedge clk); #1;
    startOfFrame = 1'b0;
    prioWr       = 1'b0;
    enMaskWr     = 1'b0;
  endtask

  task automatic rst_cycle(input string nm);
    reset = 1'b1;
    push(cyc + 1, 2, 8'h00, 4'h0, 1'b0, 9'h000, nm);
    @(posedge clk); #1;
    reset        = 1'b0;
    startOfFrame = 1'b0;
    prioWr       = 1'b0;
    enMaskWr     = 1'b0;
  endtask

  task automatic push_col(input logic [8:0] col, input string nm);
    push(cyc + 1, 1, 8'h00, 4'h0, 1'b0, col, nm);
  endtask

  task automatic wr_prio(input logic [3:0] slot, input logic [3:0] layer);
    prioWr = 1'b1; prioSlot = slot; prioLayer = layer;
  endtask

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; layerReq = '0; bgrRGB = BG;
    prioWr = 1'b0; prioSlot = '0; prioLayer = '0;
    enMaskWr = 1'b0; enMaskIn = '0; blinkMask = '0;
    for (int i = 0; i < NL; i++)
      layerRGB[i*CW +: CW] = (i == 0) ? 8'hE0 : (i == 1) ? 8'h1C : (i == 2) ? 8'h03 : 8'(8'h10 + i);
    @(posedge clk); #1;
    rst_cycle("reset_state_a");
    rst_cycle("reset_state_b");

    // Identity table, single and multiple requesters
    pix(9'h003, 0, 1, 8'hE0, 4'd0, 1, "basic_l0");
    pix(9'h000, 0, 1, BG,    4'd0, 0, "bg_none");
    pix(9'h004, 0, 1, 8'h03, 4'd2, 1, "l2_alone");

    // Priority swap: shadow only until frame start
    wr_prio(4'd0, 4'd1);
    pix(9'h003, 0, 1, 8'hE0, 4'd0, 1, "prio_no_sof");
    pix(9'h003, 1, 1, 8'h1C, 4'd1, 1, "prio_commit");
    wr_prio(4'd2, 4'd0);
    pix(9'h005, 0, 1, 8'hE0, 4'd0, 1, "swap_pending");
    pix(9'h005, 1, 1, 8'h03, 4'd2, 1, "swap_commit");

    // Out-of-range writes leave the table alone
    wr_prio(4'd9, 4'd0);
    pix(9'h005, 0, 1, 8'h03, 4'd2, 1, "bad_slot");
    wr_prio(4'd0, 4'd12);
    pix(9'h003, 0, 1, 8'h1C, 4'd1, 1, "bad_layer");
    pix(9'h003, 1, 1, 8'h1C, 4'd1, 1, "bad_commit");
    pix(9'h005, 0, 1, 8'h03, 4'd2, 1, "bad_keep");

    // Enable mask
    enMaskWr = 1'b1; enMaskIn = 9'h1FE;
    pix(9'h001, 0, 1, 8'hE0, 4'd0, 1, "en_pending");
    pix(9'h001, 1, 1, BG,    4'd0, 0, "en_commit");
    pix(9'h003, 0, 1, 8'h1C, 4'd1, 1, "en_l1_still");
    enMaskWr = 1'b1; enMaskIn = 9'h1FF;
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    pix(9'h000, 1, 0, 8'h00, 4'd0, 0, "");

    // Mid-frame reset also overrides a concurrent write and frame start
    pix(9'h003, 0, 1, 8'h1C, 4'd1, 1, "pre_reset");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    layerReq = 9'h003; startOfFrame = 1'b1; wr_prio(4'd0, 4'd1);
    rst_cycle("reset_mid");
    pix(9'h003, 0, 1, 8'hE0, 4'd0, 1, "post_reset_identity");

    // Blink: layer2 blinks, layer3 steady; hidden for counter 8..15
    blinkMask = 9'h004;
    for (int f = 1; f <= 17; f++) begin
      automatic bit vis = ((f % 16) < 8);
      pix(9'h00C, 1, 1, vis ? 8'h03 : 8'h13, vis ? 4'd2 : 4'd3, 1, $sformatf("blink_sof_f%0d", f));
      pix(9'h00C, 0, 1, vis ? 8'h03 : 8'h13, vis ? 4'd2 : 4'd3, 1, $sformatf("blink_px_f%0d", f));
    end
    blinkMask = 9'h000;

    // Collision reporting across frame boundaries
    push_col(9'h00C, "col_prev_frame");
    pix(9'h000, 1, 0, 8'h00, 4'd0, 0, "");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    push_col(9'h00C, "col_boundary");
    pix(9'h000, 1, 0, 8'h00, 4'd0, 0, "");
    pix(9'h030, 0, 1, 8'h14, 4'd4, 1, "overlap_px");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    push_col(9'h030, "col_hit");
    pix(9'h000, 1, 0, 8'h00, 4'd0, 0, "");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    pix(9'h000, 0, 0, 8'h00, 4'd0, 0, "");
    push_col(9'h000, "col_clear");
    pix(9'h000, 1, 0, 8'h00, 4'd0, 0, "");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations never came due, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
